// File: rtl/branch_predictor_if.sv
// Fetch-prediction and execute-resolution bundle shared by the pipeline and the branch predictor.
// The pipeline drives the master side; the predictor takes the slave side.
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc,
               perf_branches, perf_mispredicts
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc,
               perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Purpose: direct-mapped BHT (2-bit counters) + BTB predictor with EX-stage update and mispredict redirect.
// Latency: prediction and mispredict are combinational; table/perf updates are visible the next cycle.
// Backpressure: none; the pipeline must present each EX instruction with ex_valid=1 exactly once.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    branch_predictor_if.slave bp
);
    localparam int TAG_W = 30 - IDX_W;

    logic [1:0]       r_cnt [ENTRIES];
    logic [ENTRIES-1:0] r_vld;
    logic [TAG_W-1:0] r_tag [ENTRIES];
    logic [31:0]      r_tgt [ENTRIES];
    logic [31:0]      r_perf_br;
    logic [31:0]      r_perf_mis;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_hit;
    logic             w_br;
    logic             w_alias;
    logic             w_mis;

    assign w_if_idx = bp.if_pc[IDX_W+1:2];
    assign w_if_tag = bp.if_pc[31:IDX_W+2];
    assign w_ex_idx = bp.ex_pc[IDX_W+1:2];
    assign w_ex_tag = bp.ex_pc[31:IDX_W+2];

    // Prediction reads registered state only: an update to the same index shows up next cycle.
    assign w_hit          = r_vld[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign bp.pred_taken  = w_hit && r_cnt[w_if_idx][1];
    assign bp.pred_target = bp.pred_taken ? r_tgt[w_if_idx] : bp.if_pc + 32'd4;

    assign w_br    = bp.ex_valid && bp.ex_is_branch;
    assign w_alias = bp.ex_valid && !bp.ex_is_branch && bp.ex_pred_taken;

    always_comb begin
        w_mis = 1'b0;
        if (w_br) begin
            w_mis = (bp.ex_taken != bp.ex_pred_taken) ||
                    (bp.ex_taken && (bp.ex_pred_target != bp.ex_target));
        end else if (w_alias) begin
            w_mis = 1'b1;
        end
    end

    assign bp.mispredict       = w_mis;
    assign bp.redirect_pc      = (w_br && bp.ex_taken) ? bp.ex_target : bp.ex_pc + 32'd4;
    assign bp.perf_branches    = r_perf_br;
    assign bp.perf_mispredicts = r_perf_mis;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i] <= 2'b01;
            end
            r_vld      <= '0;
            r_perf_br  <= '0;
            r_perf_mis <= '0;
        end else begin
            if (w_br) begin
                if (bp.ex_taken) begin
                    if (r_cnt[w_ex_idx] != 2'b11) begin
                        r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + 2'd1;
                    end
                    r_vld[w_ex_idx] <= 1'b1;
                end else if (r_cnt[w_ex_idx] != 2'b00) begin
                    r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - 2'd1;
                end
            end else if (w_alias) begin
                r_vld[w_ex_idx] <= 1'b0;
            end
            if (w_br && (r_perf_br != 32'hFFFF_FFFF)) begin
                r_perf_br <= r_perf_br + 32'd1;
            end
            if (w_mis && (r_perf_mis != 32'hFFFF_FFFF)) begin
                r_perf_mis <= r_perf_mis + 32'd1;
            end
        end
    end

    // Tag/target need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (rst_n && w_br && bp.ex_taken) begin
            r_tag[w_ex_idx] <= w_ex_tag;
            r_tgt[w_ex_idx] <= bp.ex_target;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_branch_predictor;
    logic clk;
    logic rst_n;

    branch_predictor_if bp ();

    branch_predictor #(.ENTRIES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam int S_PT = 0, S_PTGT = 1, S_MIS = 2, S_RPC = 3, S_PB = 4, S_PM = 5;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_PT:    return {31'd0, bp.pred_taken};
            S_PTGT:  return bp.pred_target;
            S_MIS:   return {31'd0, bp.mispredict};
            S_RPC:   return bp.redirect_pc;
            S_PB:    return bp.perf_branches;
            default: return bp.perf_mispredicts;
        endcase
    endfunction

    // Monitor: outputs are sampled on the falling edge, half a cycle after inputs settle.
    initial begin
        chk_t c;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                c   = sb_q.pop_front();
                act = actual(c.sel);
                n_checks++;
                if (act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
                end
            end
        end
    end

    task automatic push_exp(input string name, input int sel, input logic [31:0] v);
        sb_q.push_back('{name, sel, v});
    endtask

    task automatic exp_pred(input string name, input logic pt, input logic [31:0] tgt);
        push_exp({name, ".pred_taken"}, S_PT, {31'd0, pt});
        push_exp({name, ".pred_target"}, S_PTGT, tgt);
    endtask

    task automatic exp_mis(input string name, input logic mis, input logic [31:0] rpc);
        push_exp({name, ".mispredict"}, S_MIS, {31'd0, mis});
        push_exp({name, ".redirect_pc"}, S_RPC, rpc);
    endtask

    task automatic exp_perf(input string name, input logic [31:0] b, input logic [31:0] m);
        push_exp({name, ".perf_branches"}, S_PB, b);
        push_exp({name, ".perf_mispredicts"}, S_PM, m);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] pc);
        step();
        bp.if_pc          = pc;
        bp.ex_valid       = 1'b0;
        bp.ex_is_branch   = 1'b0;
        bp.ex_pc          = 32'h0;
        bp.ex_taken       = 1'b0;
        bp.ex_target      = 32'h0;
        bp.ex_pred_taken  = 1'b0;
        bp.ex_pred_target = 32'h0;
    endtask

    task automatic resolve(input logic [31:0] ifpc, input logic vld, input logic isbr,
                           input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        step();
        bp.if_pc          = ifpc;
        bp.ex_valid       = vld;
        bp.ex_is_branch   = isbr;
        bp.ex_pc          = pc;
        bp.ex_taken       = tk;
        bp.ex_target      = tgt;
        bp.ex_pred_taken  = ptk;
        bp.ex_pred_target = ptgt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle(32'h100);
        idle(32'h100);
        step();
        rst_n = 1'b1;

        // Reset state
        idle(32'h100);
        exp_pred("reset", 1'b0, 32'h104);
        exp_mis("reset", 1'b0, 32'h4);
        exp_perf("reset", 32'd0, 32'd0);

        // First taken resolve; IF on same index sees pre-update state
        resolve(32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        exp_mis("first_taken", 1'b1, 32'h80);
        exp_pred("first_taken_same_cycle", 1'b0, 32'h104);

        idle(32'h100);
        exp_pred("after_first_taken", 1'b1, 32'h80);
        exp_perf("after_first_taken", 32'd1, 32'd1);

        // Three correctly predicted taken resolves -> counter saturates
        for (int k = 0; k < 3; k++) begin
            resolve(32'h100, 1, 1, 32'h100, 1, 32'h80, 1, 32'h80);
            exp_mis("taken_correct", 1'b0, 32'h80);
        end

        // First not-taken: 11 -> 10, still predicts taken
        resolve(32'h100, 1, 1, 32'h100, 0, 32'h80, 1, 32'h80);
        exp_mis("nt1", 1'b1, 32'h104);
        idle(32'h100);
        exp_pred("after_nt1", 1'b1, 32'h80);
        exp_perf("after_nt1", 32'd5, 32'd2);

        // Second not-taken: 10 -> 01, predicts not-taken
        resolve(32'h100, 1, 1, 32'h100, 0, 32'h80, 1, 32'h80);
        exp_mis("nt2", 1'b1, 32'h104);
        idle(32'h100);
        exp_pred("after_nt2", 1'b0, 32'h104);
        exp_perf("after_nt2", 32'd6, 32'd3);

        // Aliasing: 0x100 and 0x140 share index 0
        resolve(32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104);
        exp_mis("alias_a", 1'b1, 32'h200);
        resolve(32'h100, 1, 1, 32'h140, 1, 32'h300, 0, 32'h144);
        exp_mis("alias_b", 1'b1, 32'h300);
        exp_pred("alias_b_old_value", 1'b1, 32'h200);
        idle(32'h100);
        exp_pred("alias_0x100_miss", 1'b0, 32'h104);
        idle(32'h140);
        exp_pred("alias_0x140_hit", 1'b1, 32'h300);
        exp_perf("alias", 32'd8, 32'd5);

        // Stale alias: non-branch predicted taken invalidates the entry
        resolve(32'h140, 1, 0, 32'h140, 0, 32'h0, 1, 32'h300);
        exp_mis("stale_alias", 1'b1, 32'h144);
        idle(32'h140);
        exp_pred("after_invalidate", 1'b0, 32'h144);
        exp_perf("after_invalidate", 32'd8, 32'd6);

        // ex_valid=0 must neither redirect nor update
        resolve(32'h140, 0, 1, 32'h140, 1, 32'h300, 0, 32'h144);
        exp_mis("ex_invalid", 1'b0, 32'h144);
        // Plain non-branch not predicted taken
        resolve(32'h140, 1, 0, 32'h200, 0, 32'h0, 0, 32'h204);
        exp_mis("non_branch", 1'b0, 32'h204);
        idle(32'h140);
        exp_pred("after_ex_invalid", 1'b0, 32'h144);
        exp_perf("after_ex_invalid", 32'd8, 32'd6);

        // Direction right, target wrong; counter survived invalidation at 11
        resolve(32'h140, 1, 1, 32'h140, 1, 32'h300, 1, 32'h500);
        exp_mis("target_wrong", 1'b1, 32'h300);
        idle(32'h140);
        exp_pred("after_target_wrong", 1'b1, 32'h300);
        exp_perf("after_target_wrong", 32'd9, 32'd7);

        // PC wraparound on the fall-through target
        idle(32'hFFFF_FFFC);
        exp_pred("wrap", 1'b0, 32'h0);

        // Reset wins over a same-cycle taken update
        step();
        rst_n = 1'b0;
        bp.if_pc          = 32'h108;
        bp.ex_valid       = 1'b1;
        bp.ex_is_branch   = 1'b1;
        bp.ex_pc          = 32'h108;
        bp.ex_taken       = 1'b1;
        bp.ex_target      = 32'h400;
        bp.ex_pred_taken  = 1'b0;
        bp.ex_pred_target = 32'h10C;
        exp_mis("reset_update_comb", 1'b1, 32'h400);
        step();
        rst_n = 1'b1;
        bp.ex_valid = 1'b0;
        exp_pred("reset_update", 1'b0, 32'h10C);
        exp_perf("reset_update", 32'd0, 32'd0);
        idle(32'h140);
        exp_pred("reset_clears_0x140", 1'b0, 32'h144);

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch prediction unit for the RV32I pipeline.
- In IF it predicts direction and target for the current PC using a direct-mapped BHT (2-bit saturating counters) plus a BTB.
- In EX it takes the resolved outcome from the branch decider (Branch plus computed target), updates its tables, and raises a mispredict redirect.
- It is the predicting end of the predict/resolve pair; the branch decider is the resolving end.

Parameters:
- ENTRIES, 16: number of BHT/BTB entries; power of two, at least 2.
- IDX_W, $clog2(ENTRIES): index width; index = pc[IDX_W+1:2].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- if_pc  in  32  PC being fetched
- pred_taken  out  1  predicted taken (combinational from if_pc and table state)
- pred_target  out  32  predicted next PC
- ex_valid  in  1  EX stage holds a valid instruction (not bubble/flushed)
- ex_is_branch  in  1  EX instruction opcode is 1100011
- ex_pc  in  32  PC of EX instruction
- ex_taken  in  1  resolved Branch from branch decider
- ex_target  in  32  resolved branch target (pc + B-imm)
- ex_pred_taken  in  1  pred_taken carried down the pipe with this instruction
- ex_pred_target  in  32  pred_target carried down the pipe
- mispredict  out  1  flush IF/ID and redirect (combinational)
- redirect_pc  out  32  correct next PC when mispredict=1
- perf_branches  out  32  resolved branch count
- perf_mispredicts  out  32  mispredict count

Behaviour:
- Storage per entry: cnt[1:0], valid, tag = pc[31:IDX_W+2], target[31:0].
- Sync reset (rst_n=0 at posedge):
  - all cnt=2'b01 (weakly not-taken), all valid=0, perf counters=0.
  - mispredict and redirect_pc are combinational from inputs, so they are not forced by reset.
  - During reset, table state reads as reset values.
- Prediction (IF, zero latency):
  - hit = valid[i] && tag[i]==if_pc[31:IDX_W+2].
  - pred_taken = hit && cnt[i][1].
  - pred_target = pred_taken ? target[i] : if_pc+4, computed mod 2^32 (0xFFFFFFFC+4 = 0).
- Resolution (EX), active only when ex_valid=1:
  - Branch (ex_is_branch=1):
    - mispredict = (ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target).
    - redirect_pc = ex_taken ? ex_target : ex_pc+4.
  - Non-branch with ex_pred_taken=1 (stale alias): mispredict=1, redirect_pc=ex_pc+4.
  - Otherwise mispredict=0, redirect_pc=ex_pc+4.
  - ex_valid=0: mispredict=0, no table or perf update.
- Table update at posedge, using index j from ex_pc:
  - Branch taken: cnt[j] saturating +1 (max 11); valid=1, tag and target written.
  - Branch not-taken: cnt[j] saturating -1 (min 00); BTB fields unchanged.
  - Non-branch with ex_pred_taken=1: valid[j]=0; cnt unchanged.
  - On tag mismatch for a taken branch: entry replaced; cnt is not reset (shared aliasing counter).
- Same-cycle read/write to the same index: IF sees the pre-update value; the new value is visible the next cycle. No bypass.
- Perf counters:
  - perf_branches +1 per valid resolved branch.
  - perf_mispredicts +1 per cycle with mispredict=1.
  - Both saturate at 0xFFFFFFFF; registered, visible the cycle after the event.
- Reset takes priority over any update in the same cycle.
- No stall input. The pipeline must deassert ex_valid for repeated or stalled EX cycles so that each instruction updates once.

Test Plan:
- Reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104; perf counters 0.
- Branch at 0x100 resolved taken to 0x80 (ex_pred_taken=0) → mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 gives pred_taken=1, pred_target=0x80 (cnt 01→10). perf_mispredicts=1, perf_branches=1.
- Same branch resolved taken 3 more times → cnt saturates at 11. Then two not-taken (each ex_pred_taken=1) → first: mispredict=1, redirect_pc=0x104, cnt=10, still predicts taken. Second → cnt=01, predicts not-taken.
- Taken at 0x100 (target 0x200), then taken at 0x140 (same index with ENTRIES=16, different tag, target 0x300) → 0x100 misses (pred_taken=0), 0x140 hits with target 0x300.
- Non-branch at 0x140 arrives with ex_pred_taken=1 → mispredict=1, redirect_pc=0x144, entry invalidated; next lookup of 0x140 gives pred_taken=0.
- ex_valid=0 with ex_is_branch=1, ex_taken=1 → mispredict=0, no counter change. Also: a resolve and an if_pc lookup to the same index in one cycle → IF returns the old value. Also: rst_n=0 during a taken update → entry stays invalid.
